fp_normalizer: RTL

- Multi-cycle normalization front-end for the 8-bit barrel shifter in the arithmetic datapath.
- Accepts a mantissa/exponent pair over a valid/ready handshake and scans for the leading one, one bit per cycle.
- Drives the external barrel shifter (left shift by the leading-zero count, clamped by the exponent) and registers the normalized result with its flags.
- Output is delivered over a valid/ready handshake.

---
 rtl/fp_normalizer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fp_normalizer.sv
// ============================================================================
// fp_normalizer : serial leading-one scan driving an external barrel shifter
// Revision      : 1.0
// ============================================================================
`default_nettype none

module fp_normalizer #(
   parameter int MW = 8,
   parameter int EW = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [MW-1:0]          in_mant,
   input  logic [EW-1:0]          in_exp,
   output logic [MW-1:0]          sh_inp,
   output logic [$clog2(MW)-1:0]  sh_shamt,
   output logic                   sh_dir,
   input  logic [MW-1:0]          sh_out,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [MW-1:0]          out_mant,
   output logic [EW-1:0]          out_exp,
   output logic                   out_zero,
   output logic                   out_uflow
);

   localparam int SW = $clog2(MW);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [MW-1:0]  mant_r;
   logic [EW-1:0]  exp_r;
   logic [SW-1:0]  lzc;
   logic [SW-1:0]  ptr;
   logic           uflow;
   logic [SW-1:0]  amt;
   logic [EW-1:0]  new_exp;

   // Clamping the shift to the exponent keeps new_exp from wrapping below zero.
   assign uflow   = EW'(lzc) > exp_r;
   assign amt     = uflow ? exp_r[SW-1:0] : lzc;
   assign new_exp = exp_r - EW'(amt);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mant_r    <= '0;
         exp_r     <= '0;
         lzc       <= '0;
         ptr       <= '0;
         out_mant  <= '0;
         out_exp   <= '0;
         out_zero  <= 1'b0;
         out_uflow <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mant_r <= in_mant;
                  exp_r  <= in_exp;
                  lzc    <= '0;
                  ptr    <= SW'(MW - 1);
               end
            end
            SCAN: begin
               if (!mant_r[ptr]) begin
                  if (ptr != '0) begin
                     lzc <= lzc + SW'(1);
                     ptr <= ptr - SW'(1);
                  end else begin
                     out_mant  <= '0;
                     out_exp   <= '0;
                     out_zero  <= 1'b1;
                     out_uflow <= 1'b0;
                  end
               end
            end
            SHIFT: begin
               out_mant  <= sh_out;
               out_exp   <= new_exp;
               out_zero  <= 1'b0;
               out_uflow <= uflow;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      sh_inp    = '0;
      sh_shamt  = '0;
      sh_dir    = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = SCAN;
         end
         SCAN: begin
            if (mant_r[ptr])      state_nx = SHIFT;
            else if (ptr == '0)   state_nx = DONE;
         end
         SHIFT: begin
            sh_inp   = mant_r;
            sh_shamt = amt;
            sh_dir   = 1'b1;
            state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

`default_nettype wire
